// File: rtl/vec_mem_sequencer_pkg.sv
// Shared definitions for the vector memory-stage sequencer.
//   state_e       : sequencer states (idle, issuing beats, result cycle)
//   LANES_DEFAULT : default number of 32-bit lanes per vector register
//   WORD_W        : width of one memory beat / vector lane
//   lane_lo()     : low bit position of a lane inside a flat lane bus
package vec_mem_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned LANES_DEFAULT = 4;
  localparam int unsigned WORD_W        = 32;

  function automatic int unsigned lane_lo(input int unsigned lane);
    return lane * WORD_W;
  endfunction

endpackage

// File: rtl/vec_mem_sequencer_lane_buffer.sv
// Lane buffer: LANES x 32-bit register file collecting load beats.
//   clk, rst_n : clock, asynchronous active-low reset (clears all lanes)
//   we         : write strobe for one lane
//   widx       : lane written when we is high
//   wdata      : word written into lane widx
//   rdata_flat : all lanes, lane i at bits [32i+31:32i]
module vec_mem_sequencer_lane_buffer
  import vec_mem_sequencer_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                we,
  input  logic [$clog2(LANES)-1:0]            widx,
  input  logic [WORD_W-1:0]                   wdata,
  output logic [LANES*WORD_W-1:0]             rdata_flat
);

  logic [LANES*WORD_W-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[lane_lo(32'(widx)) +: WORD_W] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_flat = mem_q;

endmodule

// File: rtl/vec_mem_sequencer.sv
// Memory-stage sequencer. Turns a scalar load/store into one data-memory
// beat and a vector load/store into LANES consecutive word beats, stalls the
// pipeline until the access completes and presents the load result.
//   clk, rst_n          : clock, asynchronous active-low reset
//   op_valid            : MEM-stage instruction valid
//   mem_read/mem_write  : load / store request (write wins if both)
//   vector_op           : vector access (LANES beats)
//   addr                : base byte address (low two bits ignored, flagged)
//   wdata, wdata_vec    : scalar / vector store data
//   stall               : hold upstream stages
//   result_valid        : one-cycle completion pulse
//   rdata, rdata_vec    : load result (held until the next completion)
//   misalign            : base address was not word aligned
//   dmem_*              : single-beat data-memory request/response
module vec_mem_sequencer
  import vec_mem_sequencer_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEFAULT,
  parameter int unsigned AW    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      op_valid,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic                      vector_op,
  input  logic [AW-1:0]             addr,
  input  logic [WORD_W-1:0]         wdata,
  input  logic [LANES*WORD_W-1:0]   wdata_vec,
  output logic                      stall,
  output logic                      result_valid,
  output logic [WORD_W-1:0]         rdata,
  output logic [LANES*WORD_W-1:0]   rdata_vec,
  output logic                      misalign,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [AW-1:0]             dmem_addr,
  output logic [WORD_W-1:0]         dmem_wdata,
  input  logic [WORD_W-1:0]         dmem_rdata,
  input  logic                      dmem_ack
);

  localparam int unsigned BW = $clog2(LANES);
  localparam int unsigned VW = LANES * WORD_W;
  localparam logic [BW-1:0] LAST_VEC = BW'(LANES - 1);

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [AW-1:0]     base_q, base_d;
  logic              we_q, we_d;
  logic              vec_q, vec_d;
  logic              mis_q, mis_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [VW-1:0]     wvec_q, wvec_d;
  logic [VW-1:0]     hold_vec_q, hold_vec_d;
  logic              hold_mis_q, hold_mis_d;

  logic              start;
  logic              buf_we;
  logic [BW-1:0]     last_idx;
  logic [VW-1:0]     buf_flat;
  logic [VW-1:0]     cur_vec;

  // Gating with rst_n keeps the combinational start-cycle stall low while
  // reset is asserted, so every output is zero during reset.
  assign start    = rst_n & op_valid & (mem_read | mem_write);
  assign last_idx = vec_q ? LAST_VEC : '0;
  assign cur_vec  = vec_q ? buf_flat
                          : {{(VW - WORD_W){1'b0}}, buf_flat[WORD_W-1:0]};

  vec_mem_sequencer_lane_buffer #(
    .LANES (LANES)
  ) u_lane_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (buf_we),
    .widx       (beat_q),
    .wdata      (dmem_rdata),
    .rdata_flat (buf_flat)
  );

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    base_d       = base_q;
    we_d         = we_q;
    vec_d        = vec_q;
    mis_d        = mis_q;
    wdata_d      = wdata_q;
    wvec_d       = wvec_q;
    hold_vec_d   = hold_vec_q;
    hold_mis_d   = hold_mis_q;
    stall        = 1'b0;
    result_valid = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = '0;
    dmem_wdata   = '0;
    buf_we       = 1'b0;
    rdata_vec    = hold_vec_q;
    misalign     = hold_mis_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          stall   = 1'b1;
          base_d  = {addr[AW-1:2], 2'b00};
          we_d    = mem_write;
          vec_d   = vector_op;
          mis_d   = |addr[1:0];
          wdata_d = wdata;
          wvec_d  = wdata_vec;
          beat_d  = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall      = 1'b1;
        dmem_req   = 1'b1;
        dmem_we    = we_q;
        // AW-bit addition: the beat address wraps silently past the top.
        dmem_addr  = base_q + AW'({beat_q, 2'b00});
        dmem_wdata = vec_q ? wvec_q[lane_lo(32'(beat_q)) +: WORD_W] : wdata_q;
        if (dmem_ack) begin
          buf_we = ~we_q;
          if (beat_q == last_idx) begin
            state_d = ST_DONE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      ST_DONE: begin
        // The instruction is still presented here; returning to IDLE
        // unconditionally keeps it from being issued a second time.
        result_valid = 1'b1;
        rdata_vec    = cur_vec;
        misalign     = mis_q;
        hold_vec_d   = cur_vec;
        hold_mis_d   = mis_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rdata = rdata_vec[WORD_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      we_q       <= 1'b0;
      vec_q      <= 1'b0;
      mis_q      <= 1'b0;
      wdata_q    <= '0;
      wvec_q     <= '0;
      hold_vec_q <= '0;
      hold_mis_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      we_q       <= we_d;
      vec_q      <= vec_d;
      mis_q      <= mis_d;
      wdata_q    <= wdata_d;
      wvec_q     <= wvec_d;
      hold_vec_q <= hold_vec_d;
      hold_mis_q <= hold_mis_d;
    end
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
module tb_vec_mem_sequencer;

  localparam int LANES = 4;
  localparam int AW    = 32;
  localparam int VW    = LANES * 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            op_valid = 1'b0;
  logic            mem_read = 1'b0;
  logic            mem_write = 1'b0;
  logic            vector_op = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic [31:0]     wdata = '0;
  logic [VW-1:0]   wdata_vec = '0;
  logic            stall;
  logic            result_valid;
  logic [31:0]     rdata;
  logic [VW-1:0]   rdata_vec;
  logic            misalign;
  logic            dmem_req;
  logic            dmem_we;
  logic [AW-1:0]   dmem_addr;
  logic [31:0]     dmem_wdata;
  logic [31:0]     dmem_rdata = '0;
  logic            dmem_ack = 1'b0;

  vec_mem_sequencer #(.LANES(LANES), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_valid     (op_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .vector_op    (vector_op),
    .addr         (addr),
    .wdata        (wdata),
    .wdata_vec    (wdata_vec),
    .stall        (stall),
    .result_valid (result_valid),
    .rdata        (rdata),
    .rdata_vec    (rdata_vec),
    .misalign     (misalign),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          rd;
    bit          wr;
    bit          vec;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [VW-1:0] wvec;
    int          delay;
    logic [31:0] salt;
    int          exp_stall;
    logic [31:0] exp_addr0;
    logic [31:0] exp_rdata;
    bit          exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [31:0] d;
  } beat_t;

  int          checks = 0;
  int          failures = 0;
  beat_t       seen[$];
  logic [31:0] mbuf [LANES];
  int          obs_stall;
  logic [31:0] obs_addr0;
  logic [31:0] obs_rdata;
  logic [VW-1:0] obs_vec;
  logic        obs_mis;

  // Memory responder: acks after ack_delay waiting cycles per beat and
  // returns address ^ rd_salt as read data.
  int          ack_delay = 0;
  logic [31:0] rd_salt = '0;
  int          wait_cnt = 0;

  always @(negedge clk) begin
    if (dmem_req) begin
      if (wait_cnt >= ack_delay) begin
        dmem_ack   = 1'b1;
        dmem_rdata = dmem_addr ^ rd_salt;
        wait_cnt   = 0;
      end else begin
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        wait_cnt++;
      end
    end else begin
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      wait_cnt   = 0;
    end
  end

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t o, input bit drop_after);
    int            n;
    int            stall_cnt;
    bit            got;
    bit            prev_wait;
    logic [31:0]   pa, pd;
    logic          pw;
    logic [31:0]   ea;
    logic [VW-1:0] exp_vec;
    seen.delete();
    @(posedge clk); #1;
    op_valid  = 1'b1;
    mem_read  = o.rd;
    mem_write = o.wr;
    vector_op = o.vec;
    addr      = o.addr;
    wdata     = o.wdata;
    wdata_vec = o.wvec;
    ack_delay = o.delay;
    rd_salt   = o.salt;
    stall_cnt = 0;
    got       = 1'b0;
    prev_wait = 1'b0;
    pa = '0; pd = '0; pw = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk); #1;
      if (c == 0) begin
        chk({o.name, " start_stall"}, stall, 1);
        chk({o.name, " start_req"}, dmem_req, 0);
      end
      if (prev_wait && dmem_req) begin
        chk({o.name, " hold_addr"}, dmem_addr, pa);
        chk({o.name, " hold_wdata"}, dmem_wdata, pd);
        chk({o.name, " hold_we"}, dmem_we, pw);
      end
      prev_wait = dmem_req && !dmem_ack;
      pa = dmem_addr; pd = dmem_wdata; pw = dmem_we;
      if (dmem_req && dmem_ack) seen.push_back('{dmem_addr, dmem_we, dmem_wdata});
      if (result_valid) begin
        got       = 1'b1;
        obs_rdata = rdata;
        obs_vec   = rdata_vec;
        obs_mis   = misalign;
        chk({o.name, " done_stall"}, stall, 0);
        chk({o.name, " done_req"}, dmem_req, 0);
      end else if (stall) begin
        stall_cnt++;
      end
    end
    chk({o.name, " completed"}, got, 1);
    obs_stall = stall_cnt;
    obs_addr0 = (seen.size() > 0) ? seen[0].a : 32'h0;

    // Reference model: n beats at base + 4i (mod 2^32); loads fill lanes.
    n = o.vec ? LANES : 1;
    chk({o.name, " stall_cycles"}, stall_cnt, 1 + n * (o.delay + 1));
    chk({o.name, " beat_count"}, seen.size(), n);
    for (int i = 0; i < n; i++) begin
      ea = {o.addr[31:2], 2'b00} + 32'(4 * i);
      if (i < seen.size()) begin
        chk({o.name, " beat_addr"}, seen[i].a, ea);
        chk({o.name, " beat_we"}, seen[i].we, o.wr);
        if (o.wr) chk({o.name, " beat_wdata"}, seen[i].d, o.vec ? o.wvec[32*i +: 32] : o.wdata);
      end
      if (!o.wr) mbuf[i] = ea ^ o.salt;
    end
    exp_vec = '0;
    if (o.vec) begin
      for (int i = 0; i < LANES; i++) exp_vec[32*i +: 32] = mbuf[i];
    end else begin
      exp_vec[31:0] = mbuf[0];
    end
    chk({o.name, " rdata_vec"}, obs_vec, exp_vec);
    chk({o.name, " rdata"}, obs_rdata, mbuf[0]);
    chk({o.name, " misalign"}, obs_mis, |o.addr[1:0]);

    if (drop_after) begin
      @(posedge clk); #1;
      op_valid  = 1'($urandom_range(0, 1));
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk); #1;
      chk({o.name, " idle_stall"}, stall, 0);
      chk({o.name, " idle_req"}, dmem_req, 0);
      chk({o.name, " idle_rv"}, result_valid, 0);
      chk({o.name, " held_rdata"}, rdata, mbuf[0]);
      chk({o.name, " held_misalign"}, misalign, |o.addr[1:0]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    vec_t o;
    int   acks;

    for (int i = 0; i < LANES; i++) mbuf[i] = '0;

    tbl[0] = '{"ldm_basic", 1, 0, 0, 32'h100, 32'h0, '0, 0, 32'hDEADBFEF,
               2, 32'h100, 32'hDEADBEEF, 0};
    tbl[1] = '{"stv_slow", 0, 1, 1, 32'h200, 32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, 1, 32'h0,
               9, 32'h200, 32'hDEADBEEF, 0};
    tbl[2] = '{"ldv_wrap", 1, 0, 1, 32'hFFFF_FFF8, 32'h0, '0, 0, 32'h1000_0000,
               5, 32'hFFFF_FFF8, 32'hEFFF_FFF8, 0};
    tbl[3] = '{"ldm_misaligned", 1, 0, 0, 32'h103, 32'h0, '0, 0, 32'h0,
               2, 32'h100, 32'h100, 1};
    tbl[4] = '{"stm_aligned", 0, 1, 0, 32'h40, 32'h55, '0, 0, 32'h0,
               2, 32'h40, 32'h100, 0};

    // Reset state
    @(negedge clk); #1;
    chk("reset stall", stall, 0);
    chk("reset req", dmem_req, 0);
    chk("reset rv", result_valid, 0);
    chk("reset rdata_vec", rdata_vec, 0);
    chk("reset misalign", misalign, 0);
    chk("reset addr", dmem_addr, 0);
    rst_n = 1'b1;

    // Directed table
    foreach (tbl[k]) begin
      run_op(tbl[k], 1'b1);
      chk({tbl[k].name, " tbl_stall"}, obs_stall, tbl[k].exp_stall);
      chk({tbl[k].name, " tbl_addr0"}, obs_addr0, tbl[k].exp_addr0);
      chk({tbl[k].name, " tbl_rdata"}, obs_rdata, tbl[k].exp_rdata);
      chk({tbl[k].name, " tbl_misalign"}, obs_mis, tbl[k].exp_mis);
    end

    // Back-to-back LDM then STM with the instruction held through DONE
    o = '{"b2b_ldm", 1, 0, 0, 32'h300, 32'h0, '0, 0, 32'hABCD_0000, 0, 0, 0, 0};
    run_op(o, 1'b0);
    o = '{"b2b_stm", 0, 1, 0, 32'h304, 32'hCAFE_F00D, '0, 0, 32'h0, 0, 0, 0, 0};
    run_op(o, 1'b1);

    // Reset during beat 2 of an LDV
    @(posedge clk); #1;
    op_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; vector_op = 1'b1;
    addr = 32'h500; ack_delay = 1; rd_salt = 32'h5A5A_0000;
    acks = 0;
    for (int c = 0; c < 50 && acks < 2; c++) begin
      @(negedge clk); #1;
      if (dmem_req && dmem_ack) acks++;
    end
    chk("rst_mid acks_before", acks, 2);
    @(posedge clk); #3;
    chk("rst_mid req_before", dmem_req, 1);
    chk("rst_mid addr_before", dmem_addr, 32'h508);
    rst_n = 1'b0;
    #1;
    chk("rst_mid req", dmem_req, 0);
    chk("rst_mid stall", stall, 0);
    chk("rst_mid rv", result_valid, 0);
    chk("rst_mid rdata_vec", rdata_vec, 0);
    op_valid = 1'b0; mem_read = 1'b0; vector_op = 1'b0;
    for (int i = 0; i < LANES; i++) mbuf[i] = '0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    o = '{"post_rst_ldm", 1, 0, 0, 32'h600, 32'h0, '0, 0, 32'h0F0F_0000, 0, 0, 0, 0};
    run_op(o, 1'b1);

    // Randomized traffic against the reference model
    for (int k = 0; k < 40; k++) begin
      o.name  = "rand";
      o.rd    = 1'($urandom_range(0, 1));
      o.wr    = 1'($urandom_range(0, 1));
      if (!o.rd && !o.wr) o.rd = 1'b1;
      o.vec   = 1'($urandom_range(0, 1));
      o.addr  = $urandom;
      if (k % 5 == 0) o.addr = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      o.wdata = $urandom;
      for (int i = 0; i < LANES; i++) o.wvec[32*i +: 32] = $urandom;
      o.delay = $urandom_range(0, 2);
      o.salt  = $urandom;
      o.exp_stall = 0; o.exp_addr0 = '0; o.exp_rdata = '0; o.exp_mis = 1'b0;
      run_op(o, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
